// File: rtl/bp_be_br_resolve_pkg.sv
// Shared BE definitions for branch resolution.
//   - bp_be_br_resolve_state_e : resolver state (run / wrong-path squash)
//   - bp_be_redirect_entry_s   : one queued redirect {pc, npc, taken}, declared per
//                                vaddr width through DECLARE_BP_BE_REDIRECT_ENTRY_S
//   - BP_BE_REDIRECT_ENTRY_WIDTH: packed width of that struct
//   - is_pow2                  : elaboration helper for depth checks

`define BP_BE_REDIRECT_ENTRY_WIDTH(vaddr_width_mp) (2*(vaddr_width_mp)+1)

`define DECLARE_BP_BE_REDIRECT_ENTRY_S(vaddr_width_mp) \
    typedef struct packed {                            \
        logic [vaddr_width_mp-1:0] pc;                 \
        logic [vaddr_width_mp-1:0] npc;                \
        logic                      taken;              \
    } bp_be_redirect_entry_s

package bp_be_br_resolve_pkg;

    typedef enum logic [0:0] {
        e_run    = 1'b0,
        e_squash = 1'b1
    } bp_be_br_resolve_state_e;

    localparam int unsigned redirect_fifo_min_els_gp = 2;

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bp_be_br_resolve_if.sv
// Redirect command bus from the branch resolver to the FE command path.
//   redirect_v_o     : head entry valid (driven by the resolver)
//   redirect_yumi_i  : consumer dequeues the head (driven by the consumer)
//   redirect_pc_o    : pc of the mispredicted branch
//   redirect_npc_o   : correct next pc
//   redirect_taken_o : resolved direction
// master = resolver side, slave = consumer side.

interface bp_be_br_resolve_if #(
    parameter int unsigned vaddr_width_p = 39
);

    logic                     redirect_v_o;
    logic                     redirect_yumi_i;
    logic [vaddr_width_p-1:0] redirect_pc_o;
    logic [vaddr_width_p-1:0] redirect_npc_o;
    logic                     redirect_taken_o;

    modport master (
        output redirect_v_o,
        output redirect_pc_o,
        output redirect_npc_o,
        output redirect_taken_o,
        input  redirect_yumi_i
    );

    modport slave (
        input  redirect_v_o,
        input  redirect_pc_o,
        input  redirect_npc_o,
        input  redirect_taken_o,
        output redirect_yumi_i
    );

endinterface

// File: rtl/bp_be_redirect_fifo.sv
// One-read/one-write FIFO with registered storage and a yumi-style dequeue.
//   clk_i, reset_i : clock, synchronous active-high reset (clears pointers and storage)
//   data_i, v_i    : enqueue data / enqueue strobe (caller keeps v_i low when full,
//                    unless yumi_i is also asserted that cycle)
//   full_o         : no free entry (from registered pointers only)
//   data_o, v_o    : head entry / head valid (no same-cycle bypass of data_i)
//   yumi_i         : dequeue the head; only meaningful while v_o=1

module bp_be_redirect_fifo
    import bp_be_br_resolve_pkg::*;
#(
    parameter int unsigned width_p = 79,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               full_o,

    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int unsigned idx_width_lp = $clog2(els_p);

    if (!is_pow2(els_p) || (els_p < redirect_fifo_min_els_gp)) begin : g_bad_depth
        $error("bp_be_redirect_fifo: els_p must be a power of 2 and at least 2");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [idx_width_lp:0] wptr_q;
    logic [idx_width_lp:0] rptr_q;
    logic [width_p-1:0]    mem_q [els_p];

    logic empty;

    always_comb begin
        empty  = (wptr_q == rptr_q);
        full_o = (wptr_q[idx_width_lp] != rptr_q[idx_width_lp])
              && (wptr_q[idx_width_lp-1:0] == rptr_q[idx_width_lp-1:0]);
        v_o    = !empty;
        data_o = mem_q[rptr_q[idx_width_lp-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(els_p); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (v_i) begin
                mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
                wptr_q                          <= wptr_q + 1'b1;
            end
            if (yumi_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_be_br_resolve.sv
// Branch resolver downstream of the integer pipe.
// Compares each resolved branch npc with the predicted npc; on a mispredict it queues a
// redirect {pc, npc, taken} and squashes wrong-path results until the pipeline flush.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   v_i, branch_i       : integer-pipe result valid / result is a branch or jump
//   btaken_i, npc_i     : resolved direction / resolved next pc
//   pc_i, pred_npc_i    : instruction pc / predicted next pc
//   misaligned_i        : misaligned-target exception (never redirected here)
//   flush_i             : pipeline flush from commit
//   ready_o             : a branch can be accepted this cycle
//   squash_o            : resolver is discarding wrong-path results
//   branch_cnt_o        : accepted branches (saturating)
//   mispred_cnt_o       : enqueued mispredicts (saturating)
//   redirect            : redirect command bus (master side)

module bp_be_br_resolve
    import bp_be_br_resolve_pkg::*;
#(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned fifo_els_p    = 2,
    parameter int unsigned ctr_width_p   = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    input  logic                     branch_i,
    input  logic                     btaken_i,
    input  logic [vaddr_width_p-1:0] npc_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [vaddr_width_p-1:0] pred_npc_i,
    input  logic                     misaligned_i,
    input  logic                     flush_i,

    output logic                     ready_o,
    output logic                     squash_o,
    output logic [ctr_width_p-1:0]   branch_cnt_o,
    output logic [ctr_width_p-1:0]   mispred_cnt_o,

    bp_be_br_resolve_if.master       redirect
);

    `DECLARE_BP_BE_REDIRECT_ENTRY_S(vaddr_width_p);

    localparam int unsigned entry_width_lp = `BP_BE_REDIRECT_ENTRY_WIDTH(vaddr_width_p);

    bp_be_br_resolve_state_e state_q, state_d;

    logic                  fifo_full;
    logic                  accept;
    logic                  mispredict;
    bp_be_redirect_entry_s enq_entry;
    bp_be_redirect_entry_s head_entry;
    logic [ctr_width_p-1:0] branch_cnt_q;
    logic [ctr_width_p-1:0] mispred_cnt_q;

    // ready_o depends only on registered state, so an enqueue and dequeue in the same
    // cycle while full still holds ready_o low for that cycle.
    always_comb begin
        ready_o    = !fifo_full || (state_q == e_squash);
        accept     = v_i && branch_i && ready_o && !flush_i && (state_q == e_run);
        mispredict = accept && !misaligned_i && (npc_i != pred_npc_i);

        enq_entry       = '0;
        enq_entry.pc    = pc_i;
        enq_entry.npc   = npc_i;
        enq_entry.taken = btaken_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_run:    if (mispredict) state_d = e_squash;
            e_squash: if (flush_i)    state_d = e_run;
            default:  state_d = e_run;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_run;
        end else begin
            state_q <= state_d;
        end
    end

    bp_be_redirect_fifo #(
        .width_p (entry_width_lp),
        .els_p   (fifo_els_p)
    ) u_redirect_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (enq_entry),
        .v_i     (mispredict),
        .full_o  (fifo_full),
        .data_o  (head_entry),
        .v_o     (redirect.redirect_v_o),
        .yumi_i  (redirect.redirect_yumi_i)
    );

    always_comb begin
        redirect.redirect_pc_o    = head_entry.pc;
        redirect.redirect_npc_o   = head_entry.npc;
        redirect.redirect_taken_o = head_entry.taken;
    end

    // Statistics counters saturate at all-ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (accept && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + ctr_width_p'(1);
            end
            if (mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + ctr_width_p'(1);
            end
        end
    end

    always_comb begin
        squash_o      = (state_q == e_squash);
        branch_cnt_o  = branch_cnt_q;
        mispred_cnt_o = mispred_cnt_q;
    end

    yumi_without_valid: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(redirect.redirect_yumi_i && !redirect.redirect_v_o)
    );

endmodule

// File: tb/tb_bp_be_br_resolve.sv
// Directed, table-driven bench for bp_be_br_resolve (fifo_els_p=2, 4-bit counters so
// saturation is reachable).

module tb_bp_be_br_resolve;

    localparam int unsigned VW = 39;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          v, branch, btaken, misaligned, flush;
    logic [VW-1:0] npc, pc, pred_npc;
    logic          ready, squash;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    int tests;
    int failed;

    bp_be_br_resolve_if #(.vaddr_width_p(VW)) redirect_if ();

    bp_be_br_resolve #(
        .vaddr_width_p (VW),
        .fifo_els_p    (2),
        .ctr_width_p   (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .v_i           (v),
        .branch_i      (branch),
        .btaken_i      (btaken),
        .npc_i         (npc),
        .pc_i          (pc),
        .pred_npc_i    (pred_npc),
        .misaligned_i  (misaligned),
        .flush_i       (flush),
        .ready_o       (ready),
        .squash_o      (squash),
        .branch_cnt_o  (branch_cnt),
        .mispred_cnt_o (mispred_cnt),
        .redirect      (redirect_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v, br, tk;
        logic [VW-1:0] pc, npc, pred;
        logic          mis, fl, yumi;
        logic          e_v, e_sq, e_rdy;
        int            e_b, e_m;
        logic          chk_head;
        logic [VW-1:0] e_pc, e_npc;
        logic          e_tk;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v_, br_, tk_, input logic [VW-1:0] pc_, npc_, pred_,
                         input logic mis_, fl_, yumi_);
        v          = v_;
        branch     = br_;
        btaken     = tk_;
        pc         = pc_;
        npc        = npc_;
        pred_npc   = pred_;
        misaligned = mis_;
        flush      = fl_;
        redirect_if.redirect_yumi_i = yumi_;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, '0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v_, br_, tk_, input logic [VW-1:0] pc_, npc_, pred_,
                       input logic mis_, fl_, yumi_,
                       input logic ev, esq, erdy, input int eb, em,
                       input logic chk, input logic [VW-1:0] epc, enpc, input logic etk);
        vec_t t;
        t.v = v_; t.br = br_; t.tk = tk_; t.pc = pc_; t.npc = npc_; t.pred = pred_;
        t.mis = mis_; t.fl = fl_; t.yumi = yumi_;
        t.e_v = ev; t.e_sq = esq; t.e_rdy = erdy; t.e_b = eb; t.e_m = em;
        t.chk_head = chk; t.e_pc = epc; t.e_npc = enpc; t.e_tk = etk;
        vecs.push_back(t);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " redirect_v"}, 64'(redirect_if.redirect_v_o), 64'd0);
        check({tag, " ready"},      64'(ready),                    64'd1);
        check({tag, " squash"},     64'(squash),                   64'd0);
        check({tag, " branch_cnt"}, 64'(branch_cnt),               64'd0);
        check({tag, " mispred_cnt"},64'(mispred_cnt),              64'd0);
        check({tag, " redirect_pc"},64'(redirect_if.redirect_pc_o),64'd0);
        check({tag, " redirect_npc"},64'(redirect_if.redirect_npc_o),64'd0);
        check({tag, " redirect_taken"},64'(redirect_if.redirect_taken_o),64'd0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        idle();

        //   v br tk pc       npc      pred     mis fl yu | v sq rdy b m chk pc npc tk
        add(1, 1, 0, 'h1000, 'h1004, 'h1004, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 'h2000, 'h2040, 'h2004, 0, 0, 0,   1, 1, 1, 2, 1, 1, 'h2000, 'h2040, 1);
        add(1, 1, 1, 'h3000, 'h3080, 'h3004, 0, 0, 0,   1, 1, 1, 2, 1, 1, 'h2000, 'h2040, 1);
        add(0, 0, 0, 0,      0,      0,      0, 1, 0,   1, 0, 1, 2, 1, 1, 'h2000, 'h2040, 1);
        add(1, 1, 0, 'h4000, 'h4100, 'h4004, 0, 0, 0,   1, 1, 1, 3, 2, 1, 'h2000, 'h2040, 1);
        add(1, 1, 1, 'h5000, 'h5080, 'h5004, 0, 1, 0,   1, 0, 0, 3, 2, 1, 'h2000, 'h2040, 1);
        add(1, 1, 1, 'h6000, 'h6200, 'h6004, 0, 0, 0,   1, 0, 0, 3, 2, 1, 'h2000, 'h2040, 1);
        add(1, 1, 1, 'h6000, 'h6200, 'h6004, 0, 0, 1,   1, 0, 1, 3, 2, 1, 'h4000, 'h4100, 0);
        add(1, 1, 1, 'h6000, 'h6200, 'h6004, 0, 0, 0,   1, 1, 1, 4, 3, 1, 'h4000, 'h4100, 0);
        add(0, 0, 0, 0,      0,      0,      0, 1, 0,   1, 0, 0, 4, 3, 1, 'h4000, 'h4100, 0);
        add(0, 0, 0, 0,      0,      0,      0, 0, 1,   1, 0, 1, 4, 3, 1, 'h6000, 'h6200, 1);
        add(0, 0, 0, 0,      0,      0,      0, 0, 1,   0, 0, 1, 4, 3, 0, 0, 0, 0);
        add(1, 1, 1, 'h7000, 'h7010, 'h7004, 0, 0, 0,   1, 1, 1, 5, 4, 1, 'h7000, 'h7010, 1);
        add(0, 0, 0, 0,      0,      0,      0, 1, 0,   1, 0, 1, 5, 4, 1, 'h7000, 'h7010, 1);
        add(1, 1, 0, 'h8000, 'h8020, 'h8004, 0, 0, 0,   1, 1, 1, 6, 5, 1, 'h7000, 'h7010, 1);
        add(0, 0, 0, 0,      0,      0,      0, 1, 1,   1, 0, 1, 6, 5, 1, 'h8000, 'h8020, 0);
        add(1, 1, 1, 'h9000, 'h9040, 'h9004, 0, 0, 1,   1, 1, 1, 7, 6, 1, 'h9000, 'h9040, 1);
        add(0, 0, 0, 0,      0,      0,      0, 1, 0,   1, 0, 1, 7, 6, 1, 'h9000, 'h9040, 1);
        add(0, 0, 0, 0,      0,      0,      0, 0, 1,   0, 0, 1, 7, 6, 0, 0, 0, 0);
        add(1, 1, 1, 'ha000, 'ha002, 'ha004, 1, 0, 0,   0, 0, 1, 8, 6, 0, 0, 0, 0);
        add(1, 0, 0, 'hb000, 'hb008, 'hb004, 0, 0, 0,   0, 0, 1, 8, 6, 0, 0, 0, 0);
        add(1, 1, 1, 'hc000, 'hc100, 'hc004, 0, 1, 0,   0, 0, 1, 8, 6, 0, 0, 0, 0);

        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");

        foreach (vecs[i]) begin
            vec_t t;
            t = vecs[i];
            drive(t.v, t.br, t.tk, t.pc, t.npc, t.pred, t.mis, t.fl, t.yumi);
            tick();
            check($sformatf("vec%0d redirect_v", i), 64'(redirect_if.redirect_v_o), 64'(t.e_v));
            check($sformatf("vec%0d squash", i),     64'(squash),                   64'(t.e_sq));
            check($sformatf("vec%0d ready", i),      64'(ready),                    64'(t.e_rdy));
            check($sformatf("vec%0d branch_cnt", i), 64'(branch_cnt),               64'(t.e_b));
            check($sformatf("vec%0d mispred_cnt", i),64'(mispred_cnt),              64'(t.e_m));
            if (t.chk_head) begin
                check($sformatf("vec%0d head_pc", i),  64'(redirect_if.redirect_pc_o),  64'(t.e_pc));
                check($sformatf("vec%0d head_npc", i), 64'(redirect_if.redirect_npc_o), 64'(t.e_npc));
                check($sformatf("vec%0d head_taken", i), 64'(redirect_if.redirect_taken_o),
                      64'(t.e_tk));
            end
        end

        // Reset while squashed with one entry queued and a mispredict on the inputs.
        drive(1, 1, 1, 'hd000, 'hd100, 'hd004, 0, 0, 0);
        tick();
        check("pre_reset squash",     64'(squash),                   64'd1);
        check("pre_reset redirect_v", 64'(redirect_if.redirect_v_o), 64'd1);
        check("pre_reset head_pc",    64'(redirect_if.redirect_pc_o),64'hd000);
        reset = 1'b1;
        drive(1, 1, 1, 'he000, 'he100, 'he004, 0, 0, 0);
        tick();
        reset = 1'b0;
        idle();
        check_reset_state("mid_squash_reset");

        // Branch counter saturation: 17 correct predictions with a 4-bit counter.
        drive(1, 1, 0, 'h1000, 'h1004, 'h1004, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick();
        idle();
        tick();
        check("sat branch_cnt",  64'(branch_cnt),  64'd15);
        check("sat mispred_cnt0", 64'(mispred_cnt), 64'd0);

        // Mispredict counter saturation: mispredict, then flush while draining.
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 1, 'h2000, 'h2040, 'h2004, 0, 0, 0);
            tick();
            drive(0, 0, 0, '0, '0, '0, 0, 1, 1);
            tick();
        end
        idle();
        tick();
        check("sat mispred_cnt", 64'(mispred_cnt), 64'd15);
        check("sat branch_hold", 64'(branch_cnt),  64'd15);
        check("sat squash",      64'(squash),      64'd0);
        check("sat empty",       64'(redirect_if.redirect_v_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bp_be_br_resolve.md
Name: bp_be_br_resolve

Overview:
- Sits directly downstream of the integer pipe in the BE calculator.
- Consumes each resolved branch or jump result: valid, branch flag, taken flag, npc and misaligned flag.
- Compares the resolved npc against the predicted npc carried with the instruction.
- On a mispredict, queues a redirect command for the FE command path and holds the block in a wrong-path squash state until the pipeline flush arrives; also keeps branch and mispredict statistics counters.

Parameters:
- vaddr_width_p, 39, virtual address width (from proc params).
- fifo_els_p, 2, redirect FIFO depth; must be a power of 2 and at least 2.
- ctr_width_p, 32, width of each statistics counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- v_i  in  1  integer-pipe result valid
- branch_i  in  1  instruction is a branch or jump
- btaken_i  in  1  resolved taken
- npc_i  in  vaddr_width_p  resolved next pc
- pc_i  in  vaddr_width_p  instruction pc
- pred_npc_i  in  vaddr_width_p  predicted next pc
- misaligned_i  in  1  instruction-misaligned exception from the integer pipe
- flush_i  in  1  pipeline flush from the commit stage
- ready_o  out  1  block can accept a branch this cycle
- redirect_v_o  out  1  redirect FIFO head valid
- redirect_yumi_i  in  1  consumer dequeues the head; legal only when redirect_v_o=1
- redirect_pc_o  out  vaddr_width_p  head: pc of the mispredicted branch
- redirect_npc_o  out  vaddr_width_p  head: correct next pc
- redirect_taken_o  out  1  head: resolved direction
- squash_o  out  1  block is in e_squash
- branch_cnt_o  out  ctr_width_p  accepted branches
- mispred_cnt_o  out  ctr_width_p  mispredicts enqueued

Behaviour:
- accept = v_i & branch_i & ready_o & !flush_i & (state==e_run).
- mispredict = accept & !misaligned_i & (npc_i != pred_npc_i).
- Misaligned branches are never redirected; the exception path owns them. They do count as branches.
- ready_o = !fifo_full | (state==e_squash). In squash state, inputs are discarded regardless of FIFO space.
- State machine:
  - e_run: on mispredict, enqueue {pc_i, npc_i, btaken_i} and go to e_squash.
  - e_squash: all inputs are ignored and neither counter increments. flush_i returns the state to e_run.
  - flush_i in e_run: stays in e_run; the same-cycle input is dropped.
- FIFO: fifo_els_p entries, registered storage, with read and write pointers one bit wider than the index.
  - Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap modulo 2*fifo_els_p.
  - Enqueue and yumi in the same cycle are allowed when full; occupancy is unchanged and ready_o stays low that cycle (ready_o is computed from registered state).
  - Enqueue and yumi in the same cycle when empty: the head is not forwarded combinationally. redirect_v_o asserts the cycle after the enqueue, so the enqueue-to-redirect_v_o latency is 1 cycle.
  - flush_i does not clear the FIFO; already-queued redirects are architecturally correct.
- Counters:
  - branch_cnt_o increments on accept.
  - mispred_cnt_o increments on mispredict.
  - Both saturate at all-ones.
- Reset (synchronous, has priority over all other inputs):
  - state=e_run; FIFO pointers=0.
  - Outputs after reset: redirect_v_o=0, squash_o=0, ready_o=1, both counters 0.
  - redirect_* data outputs are 0; FIFO storage is reset.
- Reset asserted mid-squash or with a full FIFO returns to the reset state next cycle, and pending entries are lost.
- Assertion: redirect_yumi_i while redirect_v_o=0 is an error and must be flagged in simulation.

Decomposition:
- Shared BE package: the state enum bp_be_br_resolve_state_e {e_run, e_squash} and the redirect entry struct bp_be_redirect_entry_s {pc, npc, taken}, with a width macro parameterised by vaddr_width_p.
- One sub-module: bp_be_redirect_fifo (one-read/one-write, parameterised by entry width and depth, with a yumi interface).
- Counters stay inline.

Test Plan:
- Reset then idle: after reset_i=1 for 2 cycles, check redirect_v_o=0, ready_o=1, squash_o=0 and both counters 0.
- Correct prediction: branch pc=0x1000, npc=0x1004, pred=0x1004, taken=0 → no enqueue, branch_cnt_o=1, mispred_cnt_o=0, state stays e_run.
- Mispredict: pc=0x2000, npc=0x2040, pred=0x2004, taken=1 → next cycle redirect_v_o=1 with head {0x2000, 0x2040, 1} and squash_o=1. Drive another mispredict while squashed → no enqueue and counters unchanged. Then flush_i=1 → squash_o=0 next cycle.
- FIFO full/wrap (fifo_els_p=2, yumi held low): 2 mispredicts, each followed by a flush → ready_o=0. A 3rd branch is held off. Then yumi 1 → ready_o=1. Enqueue 3 more entries across a pointer wrap → FIFO order is preserved.
- Simultaneous enqueue+yumi when full → occupancy stays 2, the correct head advances, no entry is lost.
- Misaligned: mispredicting branch with misaligned_i=1 → no redirect, branch_cnt_o increments, state stays e_run. Then reset_i asserted while in e_squash with 1 entry queued → all outputs return to reset values.
